demod_bit_packer: RTL and testbench
===================================

// Module: demod_bit_packer
// PURPOSE
//  Consumes recovered bit streams from the legacy demod (iDataClk/iBit, qDataClk/qBit,
//  bitsyncLock) and packs them into 32-bit words. Completed words go into a FIFO.
//  The host drains the FIFO over the standard register bus (rd, wr0..wr3, addr, din, dout).
//  Sits directly downstream of the demod top; all inputs are synchronous to clk.
// PARAMETERS
//  BASE_ADDR   12'h200  register block base; decodes addr[11:4]==BASE_ADDR[11:4]
//  FIFO_DEPTH  16       words, power of 2, >=4
//  CNT_W       5        log2(FIFO_DEPTH)+1, width of the fill count
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   async active-low reset
//  rd           in   1   bus read strobe (level, multi-cycle)
//  wr0..wr3     in   1   byte-lane write strobes: din[7:0]..din[31:24]
//  addr         in   12  bus address
//  din          in   32  bus write data
//  dout         out  32  read data; 0 when not selected (ORed bus)
//  iDataClk     in   1   I bit strobe; bit valid on its rising edge
//  iBit         in   1   I data bit
//  qDataClk     in   1   Q bit strobe
//  qBit         in   1   Q data bit
//  bitsyncLock  in   1   demod bit-sync lock
//  fifoNotEmpty out  1   level interrupt: FIFO holds >=1 word
// BEHAVIOUR
//  Reset: all regs 0; dout=0, fifoNotEmpty=0, FIFO empty, partial word cleared.
//  Regs (offset):
//   0x0 CTRL  rw  [0]en [1]iq (0=I only, 1=I/Q interleave) [2]msbFirst [3]lockGate
//                 [4]flush (self-clearing, reads 0)
//   0x4 STAT  ro  [CNT_W-1:0]fill [8]overflow (sticky) [9]bitsyncLock [15:10]partialCnt
//                 write 1 to bit8 clears overflow
//   0x8 DATA  ro  FIFO head word; pop on falling edge of rd while addr==DATA
//  dout combinational: selected reg while rd=1 && addr hit, else 0.
//  Edge detect: register iDataClk/qDataClk; a bit is taken when cur=1 and prev=0.
//   The bit value is sampled in that same cycle.
//  Accept = en && (!lockGate || bitsyncLock). Q edges are ignored when iq=0.
//  Same-cycle I and Q edges with iq=1: I is packed first, then Q; up to 2 bits/cycle.
//  Packing:
//   msbFirst=1 -> first bit lands in word[31]; msbFirst=0 -> first bit in word[0].
//   partialCnt counts 0..31. The 32nd bit completes the word and pushes it in the same
//   cycle; partialCnt wraps to 0.
//   If 2 bits arrive at partialCnt=31, I completes the word; Q becomes bit 0 of the
//   next word (partialCnt=1).
//  Latency: last bit edge -> word visible in FIFO/fill = 2 clk (edge reg + push).
//  Full: a push when fill==FIFO_DEPTH drops the new word, sets overflow, keeps contents.
//  Empty: pop while empty is ignored; DATA reads 0.
//  Push and pop in the same cycle: both occur and fill is unchanged (allowed when full).
//  Partial word discarded (partialCnt=0) on:
//   - flush (FIFO emptied too)
//   - en 1->0
//   - falling edge of bitsyncLock when lockGate=1
//  Flush and a push in the same cycle: flush wins and the word is lost.
//  reset_n low mid-operation: immediate clear to reset state; no partial word survives.
// STRUCTURE
//  Shared package demod_pkg:
//   - register offsets CTRL/STAT/DATA
//   - CTRL bit indices
//   - STAT field positions
//  Sub-module bit_word_fifo: sync FIFO with push/pop/flush, dout, fill, full, empty.
//  The top holds the edge detect, packer, regs and bus decode.
// TESTING
//  1. en=1, iq=0, msbFirst=1, 32 I bits of 0xA5A5_0F0F -> fill=1, DATA=32'hA5A50F0F,
//     fifoNotEmpty falls after the pop.
//  2. iq=1, I/Q edges coincident, I=1 Q=0 for 16 pairs -> word 32'hAAAA_AAAA
//     (msbFirst=1); 15.5 pairs then 1 pair straddling -> partialCnt=1.
//  3. Fill FIFO_DEPTH+1 words with no reads -> fill=16, overflow=1, head=first word;
//     W1C bit8 -> overflow=0.
//  4. lockGate=1, bitsyncLock low, 40 edges -> fill=0; lock high, 10 bits, lock drops
//     -> partialCnt=0.
//  5. Pop DATA in the same cycle a word completes at fill=16 -> fill stays 16,
//     overflow=0, ordering preserved.
//  6. reset_n asserted mid-word (partialCnt=17, fill=3) -> all regs 0, dout=0;
//     after release, packing restarts at bit 0.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared definitions for the demod bit packer: register map, field positions,
// control register layout and the bit placement helper used by the packer.
package demod_pkg;

    // Register offsets within the 16-byte block
    localparam logic [3:0] OFF_CTRL = 4'h0;
    localparam logic [3:0] OFF_STAT = 4'h4;
    localparam logic [3:0] OFF_DATA = 4'h8;

    // CTRL bit indices
    localparam int CTRL_EN        = 0;
    localparam int CTRL_IQ        = 1;
    localparam int CTRL_MSB_FIRST = 2;
    localparam int CTRL_LOCK_GATE = 3;
    localparam int CTRL_FLUSH     = 4;

    // STAT field positions
    localparam int STAT_FILL_LSB = 0;
    localparam int STAT_OVERFLOW = 8;
    localparam int STAT_LOCK     = 9;
    localparam int STAT_PCNT_LSB = 10;
    localparam int STAT_PCNT_W   = 6;

    // Packed word geometry
    localparam int WORD_W = 32;
    localparam int PCNT_W = 5;

    // Stored CTRL bits; member order matches CTRL[3:0]
    typedef struct packed {
        logic lock_gate;
        logic msb_first;
        logic iq;
        logic en;
    } ctrl_t;

    // Drop one bit into the word at the slot selected by the fill position
    function automatic logic [WORD_W-1:0] place_bit(
        input logic [WORD_W-1:0] word,
        input logic [PCNT_W-1:0] pos,
        input logic              msb_first,
        input logic              b
    );
        logic [WORD_W-1:0] w;
        w = word;
        if (msb_first) begin
            w[5'd31 - pos] = b;
        end else begin
            w[pos] = b;
        end
        return w;
    endfunction

endpackage

// File: rtl/bit_word_fifo.sv
// Synchronous word FIFO for packed demod words. Push into a full FIFO is
// dropped unless a pop happens in the same cycle; pop on empty is ignored.
// Flush empties the FIFO and wins over a simultaneous push.
module bit_word_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] fill,
    output logic             full,
    output logic             empty,
    output logic             dropped
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dropped = push && !flush && !do_push;
    assign fill    = count;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write
    // NOTE: the data array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/demod_bit_packer.sv
// Packs I (and optionally interleaved Q) demod bits into 32-bit words, queues
// them in a FIFO and exposes CTRL/STAT/DATA on the ORed register bus.
module demod_bit_packer
    import demod_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'h200,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd,
    input  logic        wr0,
    input  logic        wr1,
    input  logic        wr2,
    input  logic        wr3,
    input  logic [11:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        iDataClk,
    input  logic        iBit,
    input  logic        qDataClk,
    input  logic        qBit,
    input  logic        bitsyncLock,
    output logic        fifoNotEmpty
);

    // Bus decode
    logic sel;
    logic hit_ctrl;
    logic hit_stat;
    logic hit_data;
    logic wr_ctrl;

    assign sel      = (addr[11:4] == BASE_ADDR[11:4]);
    assign hit_ctrl = sel && (addr[3:0] == OFF_CTRL);
    assign hit_stat = sel && (addr[3:0] == OFF_STAT);
    assign hit_data = sel && (addr[3:0] == OFF_DATA);
    assign wr_ctrl  = wr0 && hit_ctrl;

    // Control state and edge-detect history
    ctrl_t ctrl_q;
    logic  i_clk_prev;
    logic  q_clk_prev;
    logic  lock_prev;
    logic  rd_prev;
    logic  overflow_q;

    // Captured bit events, one cycle after the strobe edge
    logic  i_take_q;
    logic  i_bit_q;
    logic  q_take_q;
    logic  q_bit_q;

    // Partial word
    logic [WORD_W-1:0] word_q;
    logic [PCNT_W-1:0] pcnt_q;
    logic [WORD_W-1:0] word_next;
    logic [PCNT_W-1:0] pcnt_next;
    logic              pack_push;
    logic [WORD_W-1:0] pack_word;

    // Discard sources and bit acceptance
    logic flush;
    logic en_fall;
    logic lock_fall;
    logic discard;
    logic accept;
    logic pop;

    assign flush     = wr_ctrl && din[CTRL_FLUSH];
    assign en_fall   = wr_ctrl && ctrl_q.en && !din[CTRL_EN];
    assign lock_fall = lock_prev && !bitsyncLock && ctrl_q.lock_gate;
    assign discard   = flush || en_fall || lock_fall;
    assign accept    = ctrl_q.en && (!ctrl_q.lock_gate || bitsyncLock) && !discard;
    assign pop       = rd_prev && !rd && hit_data;

    // FIFO
    logic [WORD_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_fill;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_dropped;

    bit_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pack_push && !discard),
        .push_data (pack_word),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .fill      (fifo_fill),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped)
    );

    assign fifoNotEmpty = !fifo_empty;

    // Control register, strobe history and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            i_clk_prev <= 1'b0;
            q_clk_prev <= 1'b0;
            lock_prev  <= 1'b0;
            rd_prev    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= ctrl_t'(din[CTRL_LOCK_GATE:CTRL_EN]);
            end
            i_clk_prev <= iDataClk;
            q_clk_prev <= qDataClk;
            lock_prev  <= bitsyncLock;
            rd_prev    <= rd;
            if (fifo_dropped) begin
                overflow_q <= 1'b1;
            end else if (wr1 && hit_stat && din[STAT_OVERFLOW]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Capture accepted rising strobe edges together with their data bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_take_q <= 1'b0;
            i_bit_q  <= 1'b0;
            q_take_q <= 1'b0;
            q_bit_q  <= 1'b0;
        end else begin
            i_take_q <= iDataClk && !i_clk_prev && accept;
            i_bit_q  <= iBit;
            q_take_q <= qDataClk && !q_clk_prev && accept && ctrl_q.iq;
            q_bit_q  <= qBit;
        end
    end

    // Pack up to two bits per cycle, I before Q, completing at most one word
    always_comb begin
        logic [1:0] take;
        logic [1:0] bits;
        // NOTE: every combinational output is defaulted first so no latch is inferred.
        word_next = word_q;
        pcnt_next = pcnt_q;
        pack_push = 1'b0;
        pack_word = '0;
        take      = {q_take_q, i_take_q};
        bits      = {q_bit_q, i_bit_q};
        for (int s = 0; s < 2; s++) begin
            if (take[s]) begin
                word_next = place_bit(word_next, pcnt_next, ctrl_q.msb_first, bits[s]);
                if (pcnt_next == 5'd31) begin
                    pack_push = 1'b1;
                    pack_word = word_next;
                    word_next = '0;
                    pcnt_next = '0;
                end else begin
                    pcnt_next = pcnt_next + 5'd1;
                end
            end
        end
    end

    // Partial word register; any discard source drops the word in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= '0;
            pcnt_q <= '0;
        end else if (discard) begin
            word_q <= '0;
            pcnt_q <= '0;
        end else begin
            word_q <= word_next;
            pcnt_q <= pcnt_next;
        end
    end

    // Read mux onto the ORed bus; zero unless selected during a read
    always_comb begin
        logic [31:0] stat;
        stat = '0;
        stat[STAT_FILL_LSB +: CNT_W]       = fifo_fill;
        stat[STAT_OVERFLOW]                = overflow_q;
        stat[STAT_LOCK]                    = bitsyncLock;
        stat[STAT_PCNT_LSB +: STAT_PCNT_W] = STAT_PCNT_W'(pcnt_q);
        dout = '0;
        if (rd) begin
            if (hit_ctrl) dout = {28'b0, ctrl_q};
            if (hit_stat) dout = stat;
            if (hit_data) dout = fifo_head;
        end
    end

    // Bus lanes and bits with no writable register behind them
    logic unused_bus;
    assign unused_bus = ^{wr2, wr3, din[31:9], din[7:5], fifo_full};

endmodule

// File: tb/tb_demod_bit_packer.sv
// Directed, table-driven bench for demod_bit_packer.
module tb_demod_bit_packer;

    localparam logic [11:0] BASE = 12'h200;
    localparam logic [3:0]  CTRL = 4'h0;
    localparam logic [3:0]  STAT = 4'h4;
    localparam logic [3:0]  DATA = 4'h8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0, wr3 = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        iDataClk = 1'b0, iBit = 1'b0;
    logic        qDataClk = 1'b0, qBit = 1'b0;
    logic        bitsyncLock = 1'b0;
    logic        fifoNotEmpty;

    demod_bit_packer #(
        .BASE_ADDR  (12'h200),
        .FIFO_DEPTH (16),
        .CNT_W      (5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rd           (rd),
        .wr0          (wr0),
        .wr1          (wr1),
        .wr2          (wr2),
        .wr3          (wr3),
        .addr         (addr),
        .din          (din),
        .dout         (dout),
        .iDataClk     (iDataClk),
        .iBit         (iBit),
        .qDataClk     (qDataClk),
        .qBit         (qBit),
        .bitsyncLock  (bitsyncLock),
        .fifoNotEmpty (fifoNotEmpty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        int          nev;
        logic [31:0] i_bits;
        logic [31:0] q_bits;
        logic        use_q;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] lanes);
        addr = BASE + {8'h00, off};
        din  = data;
        {wr3, wr2, wr1, wr0} = lanes;
        tick();
        {wr3, wr2, wr1, wr0} = 4'b0000;
        din = '0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
        addr = BASE + {8'h00, off};
        rd   = 1'b1;
        tick();
        data = dout;
        rd   = 1'b0;
        tick();
    endtask

    task automatic send_ev(input logic ib, input logic qs, input logic qb);
        iDataClk = 1'b1;
        iBit     = ib;
        qDataClk = qs;
        qBit     = qb;
        tick();
        iDataClk = 1'b0;
        qDataClk = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 31; k >= 0; k--) send_ev(w[k], 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] exp_pop();
        logic [31:0] v;
        if (exp_q.size() == 0) v = '0;
        else v = exp_q.pop_front();
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        int idx;

        vecs[0] = '{"v_i_msb",      5'b00101, 32, 32'hA5A5_0F0F, 32'h0,         1'b0, 32'hA5A5_0F0F};
        vecs[1] = '{"v_i_lsb",      5'b00001, 32, 32'h1234_5678, 32'h0,         1'b0, 32'h1E6A_2C48};
        vecs[2] = '{"v_q_ignored",  5'b00101, 32, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678};
        vecs[3] = '{"v_iq_msb",     5'b00111, 16, 32'h0000_FFFF, 32'h0,         1'b1, 32'hAAAA_AAAA};
        vecs[4] = '{"v_iq_lsb",     5'b00011, 16, 32'h0000_FFFF, 32'h0,         1'b1, 32'h5555_5555};
        vecs[5] = '{"v_iq_mixed",   5'b00111, 16, 32'h0000_FF00, 32'h0000_0F0F, 1'b1, 32'hAAFF_0055};

        // Reset state
        tick(); tick();
        check("rst_not_empty", {31'b0, fifoNotEmpty}, 32'h0);
        reset_n = 1'b1;
        tick();
        addr = BASE + 12'h004;
        #1;
        check("rst_dout_idle", dout, 32'h0);
        bus_read(CTRL, r); check("rst_ctrl", r, 32'h0);
        bus_read(STAT, r); check("rst_stat", r, 32'h0);
        bus_read(DATA, r); check("rst_data", r, 32'h0);

        // I-only word with two-cycle latency on the last bit
        bus_write(CTRL, 32'h5, 4'b0001);
        w = 32'hA5A5_0F0F;
        for (int k = 31; k >= 1; k--) send_ev(w[k], 1'b0, 1'b0);
        iDataClk = 1'b1;
        iBit     = w[0];
        tick();
        check("lat_edge_reg", {31'b0, fifoNotEmpty}, 32'h0);
        iDataClk = 1'b0;
        tick();
        check("lat_push", {31'b0, fifoNotEmpty}, 32'h1);
        bus_read(STAT, r); check("t1_stat", r, 32'h1);
        bus_read(DATA, r); check("t1_data", r, 32'hA5A5_0F0F);
        check("t1_not_empty", {31'b0, fifoNotEmpty}, 32'h0);

        // Table of single-word vectors
        for (int v = 0; v < 6; v++) begin
            bus_write(CTRL, {27'b0, vecs[v].ctrl}, 4'b0001);
            for (int k = 0; k < vecs[v].nev; k++) begin
                idx = vecs[v].nev - 1 - k;
                send_ev(vecs[v].i_bits[idx], vecs[v].use_q, vecs[v].q_bits[idx]);
            end
            bus_read(STAT, r); check({vecs[v].name, "_stat"}, r, 32'h1);
            bus_read(DATA, r); check({vecs[v].name, "_data"}, r, vecs[v].exp_word);
            check({vecs[v].name, "_empty"}, {31'b0, fifoNotEmpty}, 32'h0);
        end

        // I/Q straddle: 31 bits, then a pair completes the word and starts the next
        bus_write(CTRL, 32'h7, 4'b0001);
        for (int k = 0; k < 15; k++) send_ev(1'b1, 1'b1, 1'b0);
        send_ev(1'b1, 1'b0, 1'b0);
        send_ev(1'b1, 1'b1, 1'b1);
        bus_read(STAT, r); check("t2_straddle_stat", r, 32'h0000_0401);
        bus_read(DATA, r); check("t2_straddle_data", r, 32'hAAAA_AAAB);
        bus_write(CTRL, 32'h17, 4'b0001);
        bus_read(CTRL, r); check("t2_flush_reads0", r, 32'h7);
        bus_read(STAT, r); check("t2_flush_stat", r, 32'h0);

        // Overflow: 17 words into a 16-deep FIFO
        bus_write(CTRL, 32'h5, 4'b0001);
        for (int n = 0; n < 17; n++) begin
            w = 32'h1000_0000 + n;
            send_word(w);
            if (n < 16) exp_q.push_back(w);
        end
        bus_read(STAT, r); check("t3_full_ovf", r, 32'h0000_0110);
        addr = 12'h304;
        rd   = 1'b1;
        #1;
        check("t3_addr_miss", dout, 32'h0);
        addr = BASE + 12'h00C;
        #1;
        check("t3_offset_miss", dout, 32'h0);
        rd = 1'b0;
        tick();
        bus_write(STAT, 32'h0000_0100, 4'b0010);
        bus_read(STAT, r); check("t3_w1c", r, 32'h0000_0010);
        bus_read(DATA, r); check("t3_head", r, exp_pop());

        // Same-cycle push and pop at full
        w = 32'h2000_0000;
        send_word(w);
        exp_q.push_back(w);
        bus_read(STAT, r); check("t5_refill", r, 32'h0000_0010);
        w = 32'h3000_0003;
        for (int k = 31; k >= 1; k--) send_ev(w[k], 1'b0, 1'b0);
        addr     = BASE + {8'h00, DATA};
        rd       = 1'b1;
        iDataClk = 1'b1;
        iBit     = w[0];
        tick();
        r        = dout;
        rd       = 1'b0;
        iDataClk = 1'b0;
        tick();
        check("t5_pop_head", r, exp_pop());
        exp_q.push_back(w);
        bus_read(STAT, r); check("t5_fill_kept", r, 32'h0000_0010);
        for (int n = 0; n < 16; n++) begin
            bus_read(DATA, r);
            check($sformatf("t5_drain_%0d", n), r, exp_pop());
        end
        bus_read(STAT, r); check("t5_drained", r, 32'h0);

        // Lock gating and partial discard sources
        bus_write(CTRL, 32'hD, 4'b0001);
        for (int k = 0; k < 40; k++) send_ev(1'b1, 1'b0, 1'b0);
        bus_read(STAT, r); check("t4_gated", r, 32'h0);
        bitsyncLock = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) send_ev(1'b1, 1'b0, 1'b0);
        bus_read(STAT, r); check("t4_locked_pcnt", r, 32'h0000_2A00);
        bitsyncLock = 1'b0;
        tick(); tick();
        bus_read(STAT, r); check("t4_lock_drop", r, 32'h0);
        bus_write(CTRL, 32'h5, 4'b0001);
        for (int k = 0; k < 5; k++) send_ev(1'b0, 1'b0, 1'b0);
        bus_read(STAT, r); check("t4_pcnt5", r, 32'h0000_1400);
        bus_write(CTRL, 32'h4, 4'b0001);
        bus_read(STAT, r); check("t4_en_fall", r, 32'h0);
        bus_read(DATA, r); check("t4_empty_data", r, 32'h0);
        bus_read(STAT, r); check("t4_empty_pop", r, 32'h0);

        // Reset mid-word
        bus_write(CTRL, 32'h5, 4'b0001);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        for (int k = 0; k < 17; k++) send_ev(1'b1, 1'b0, 1'b0);
        bus_read(STAT, r); check("t6_pre_reset", r, 32'h0000_4403);
        reset_n = 1'b0;
        #1;
        check("t6_rst_not_empty", {31'b0, fifoNotEmpty}, 32'h0);
        rd   = 1'b1;
        addr = BASE + {8'h00, CTRL};
        #1;
        check("t6_rst_ctrl", dout, 32'h0);
        addr = BASE + {8'h00, STAT};
        #1;
        check("t6_rst_stat", dout, 32'h0);
        rd = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        bus_read(CTRL, r); check("t6_post_ctrl", r, 32'h0);
        bus_write(CTRL, 32'h5, 4'b0001);
        send_word(32'h8000_0001);
        bus_read(STAT, r); check("t6_restart_stat", r, 32'h1);
        bus_read(DATA, r); check("t6_restart_data", r, 32'h8000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
